// File: rtl/imem_loader.sv
// imem_loader: assembles a checksummed little-endian byte frame into instruction memory words and holds the core until a good load
module imem_loader #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);
  typedef enum logic [2:0] {IDLE, HDR_LO, HDR_HI, DATA, CHK, DONE, ERR} state_t;
  state_t state, state_nx;
  logic [15:0] n;
  logic [7:0] acc;
  logic [1:0] byte_idx;
  logic [23:0] word;
  logic [ADDR_W-1:0] ptr;
  logic xfer, last, idle_like;
  logic [15:0] n_full;
  assign byte_ready = state inside {HDR_LO, HDR_HI, DATA, CHK};
  assign busy = byte_ready;
  assign core_hold = state != DONE;
  assign done = state == DONE;
  assign err = state == ERR;
  assign xfer = byte_valid & byte_ready;
  assign n_full = {byte_in, n[7:0]};
  assign idle_like = state inside {IDLE, DONE, ERR};
  // words_loaded already counts every earlier word: a word needs four transfers, its predecessor's write retires in one
  assign last = byte_idx == 2'd3 && 32'(words_loaded) + 32'd1 == 32'(n);
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE, ERR: state_nx = start ? HDR_LO : state;
      HDR_LO: state_nx = xfer ? HDR_HI : state;
      HDR_HI: state_nx = !xfer ? state :
                         (n_full == 16'd0 || 32'(n_full) > (32'd1 << ADDR_W)) ? ERR : DATA;
      DATA: state_nx = (xfer && last) ? CHK : state;
      CHK: state_nx = !xfer ? state : (byte_in == acc) ? DONE : ERR;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n <= '0;
      acc <= '0;
      byte_idx <= '0;
      word <= '0;
      ptr <= '0;
      imem_we <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      words_loaded <= '0;
    end else begin
      state <= state_nx;
      imem_we <= 1'b0;
      if (imem_we) begin
        ptr <= ptr + 1'b1;
        words_loaded <= words_loaded + 1'b1;
      end
      if (idle_like && start) begin
        ptr <= '0;
        byte_idx <= '0;
        acc <= '0;
        words_loaded <= '0;
      end
      if (xfer && state == HDR_LO) n[7:0] <= byte_in;
      if (xfer && state == HDR_HI) n[15:8] <= byte_in;
      // bytes shift in from the top so lane 0 ends up lowest after three bytes
      if (xfer && state == DATA) begin
        word <= {byte_in, word[23:8]};
        acc <= acc ^ byte_in;
        byte_idx <= byte_idx + 1'b1;
        if (byte_idx == 2'd3) begin
          imem_we <= 1'b1;
          imem_waddr <= ptr;
          imem_wdata <= {byte_in, word};
        end
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames with a write scoreboard checked by a separate monitor
module tb_imem_loader;
  localparam int ADDR_W = 16;
  logic clk = 1'b0;
  logic rst, start, byte_valid;
  logic [7:0] byte_in;
  logic byte_ready, imem_we, core_hold, busy, done, err;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic [ADDR_W:0] words_loaded;
  int checks = 0;
  int errors = 0;
  logic [47:0] exp_q[$];
  logic [7:0] frame[$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .busy(busy), .done(done), .err(err), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      logic [47:0] e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %h data %h, expected no write", imem_waddr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(imem_waddr), 32'(e[47:32]));
        chk("write_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int t = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!byte_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) chk("byte_ready_timeout", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_frame(input int gap);
    foreach (frame[i]) begin
      send(frame[i]);
      if (gap != 0) @(negedge clk);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ready", 32'(byte_ready), 32'd1);
    chk("start_hold", 32'(core_hold), 32'd1);
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic status(input string name, input logic d, input logic e, input logic h, input int wl);
    chk({name, "_done"}, 32'(done), 32'(d));
    chk({name, "_err"}, 32'(err), 32'(e));
    chk({name, "_hold"}, 32'(core_hold), 32'(h));
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_words"}, 32'(words_loaded), 32'(wl));
    chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset(input string name);
    chk({name, "_ready"}, 32'(byte_ready), 32'd0);
    chk({name, "_we"}, 32'(imem_we), 32'd0);
    chk({name, "_waddr"}, 32'(imem_waddr), 32'd0);
    chk({name, "_wdata"}, imem_wdata, 32'd0);
    chk({name, "_hold"}, 32'(core_hold), 32'd1);
    chk({name, "_flags"}, {29'd0, busy, done, err}, 32'd0);
    chk({name, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  task automatic push_good();
    exp_q.push_back({16'd0, 32'h0000_0013});
    exp_q.push_back({16'd1, 32'h0010_0093});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_in = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset("reset");
    do_start();
    push_good();
    frame = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h90};
    send_frame(0);
    status("good", 1'b1, 1'b0, 1'b0, 2);
    do_start();
    chk("restart_words", 32'(words_loaded), 32'd0);
    push_good();
    frame[10] = 8'h91;
    send_frame(0);
    status("badchk", 1'b0, 1'b1, 1'b1, 2);
    do_start();
    send(8'h00);
    send(8'h00);
    status("zero_hdr", 1'b0, 1'b1, 1'b1, 0);
    byte_valid = 1'b1;
    byte_in = 8'h55;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready", 32'(byte_ready), 32'd0);
    end
    byte_valid = 1'b0;
    chk("idle_err_kept", 32'(err), 32'd1);
    do_start();
    push_good();
    frame[10] = 8'h90;
    send_frame(1);
    status("gapped", 1'b1, 1'b0, 1'b0, 2);
    do_start();
    exp_q.push_back({16'd0, 32'h0000_0013});
    for (int i = 0; i < 8; i++) send(frame[i]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("midreset");
    repeat (3) @(negedge clk);
    chk("midreset_pending", 32'(exp_q.size()), 32'd0);
    do_start();
    push_good();
    for (int i = 0; i < 5; i++) send(frame[i]);
    start = 1'b1;
    send(frame[5]);
    start = 1'b0;
    chk("busy_start_words", 32'(words_loaded), 32'd0);
    chk("busy_start_busy", 32'(busy), 32'd1);
    for (int i = 6; i < 11; i++) send(frame[i]);
    status("start_mid", 1'b1, 1'b0, 1'b0, 2);
    do_start();
    chk("reload_words", 32'(words_loaded), 32'd0);
    exp_q.push_back({16'd0, 32'h0000_1237});
    frame = '{8'h01, 8'h00, 8'h37, 8'h12, 8'h00, 8'h00, 8'h25};
    send_frame(0);
    status("reload", 1'b1, 1'b0, 1'b0, 1);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
